puf_rng_collector: RTL and testbench

- Downstream consumer of the latch-based PUF/flip-flop entropy cells.
- Takes the raw, asynchronous entropy bit produced by the master-slave latch chain and synchronises it into the system clock domain.
- Samples it at a fixed rate, removes bias with a von Neumann corrector, and packs the corrected bits MSB-first into WIDTH-bit words.
- Presents the words on a valid/ready interface, with an online repetition-count health test and sticky error flags.

---
 rtl/puf_rng_pkg.sv | 14 +
 rtl/puf_bit_sync.sv | 20 ++
 rtl/puf_rng_collector.sv | 162 ++++++++++++++++
 tb/tb_puf_rng_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_rng_pkg.sv
// rtl/puf_rng_pkg.sv - shared state encoding and default parameters for the PUF RNG collector
package puf_rng_pkg;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } vn_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SAMPLE_DIV  = 4;
  localparam int DEF_REP_LIMIT   = 32;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/puf_bit_sync.sv
// rtl/puf_bit_sync.sv - multi-flop synchroniser for the asynchronous raw entropy bit
module puf_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/puf_rng_collector.sv
// rtl/puf_rng_collector.sv - samples the raw PUF bit, von Neumann corrects it, packs words MSB-first
// and runs a repetition-count health test with sticky error flags.
module puf_rng_collector
  import puf_rng_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT   = DEF_REP_LIMIT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] rnd_word,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             overrun,
  output logic             health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic s_bit;

  puf_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (raw_bit),
    .q_o   (s_bit)
  );

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  assign tick = en && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) div_cnt_d = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
  end

  vn_state_e  state_q, state_d;
  logic       a_q, a_d;
  logic       emit, emit_bit;
  logic       health_fail_q, health_fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  // Pairs never overlap; clr and a failed health test both park the corrector in WAIT_A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    if (clr || health_fail_q) begin
      state_d = WAIT_A;
    end else if (tick) begin
      case (state_q)
        WAIT_A: begin
          a_d     = s_bit;
          state_d = WAIT_B;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_comb begin
    emit     = tick && !clr && !health_fail_q && (state_q == WAIT_B) && (a_q != s_bit);
    emit_bit = a_q;
  end

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             prev_q, prev_d;

  always_comb begin
    rep_cnt_d     = rep_cnt_q;
    prev_d        = prev_q;
    health_fail_d = health_fail_q;
    if (clr) begin
      rep_cnt_d     = '0;
      health_fail_d = 1'b0;
    end else if (tick) begin
      prev_d = s_bit;
      if (rep_cnt_q == '0 || s_bit != prev_q) rep_cnt_d = REP_W'(1);
      else if (rep_cnt_q != REP_W'(REP_LIMIT)) rep_cnt_d = rep_cnt_q + 1'b1;
      if (rep_cnt_d == REP_W'(REP_LIMIT)) health_fail_d = 1'b1;
    end
  end

  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_q, word_d, full_word;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  assign full_word = {shift_q, emit_bit};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && rnd_ready) valid_d = 1'b0;
    if (clr) begin
      bit_cnt_d = '0;
      overrun_d = 1'b0;
    end else if (emit) begin
      shift_d = full_word[WIDTH-2:0];
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        bit_cnt_d = '0;
        // A word completing while the buffer is still held is dropped, never merged.
        if (!valid_q || rnd_ready) begin
          word_d  = full_word;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      a_q           <= 1'b0;
      rep_cnt_q     <= '0;
      prev_q        <= 1'b0;
      health_fail_q <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      a_q           <= a_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_q        <= prev_d;
      health_fail_q <= health_fail_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rnd_word    = word_q;
  assign rnd_valid   = valid_q;
  assign overrun     = overrun_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_puf_rng_collector.sv
// tb/tb_puf_rng_collector.sv - self-checking bench for puf_rng_collector
module tb_puf_rng_collector;

  localparam int WIDTH       = 8;
  localparam int SAMPLE_DIV  = 4;
  localparam int REP_LIMIT   = 32;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             raw_bit = 1'b0;
  logic             rnd_ready = 1'b0;
  logic [WIDTH-1:0] rnd_word;
  logic             rnd_valid;
  logic             overrun;
  logic             health_fail;

  puf_rng_collector #(
    .WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .raw_bit(raw_bit),
    .rnd_word(rnd_word), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .overrun(overrun), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   valid_cnt = 0;
  bit   rand_ready = 1'b0;
  logic [WIDTH-1:0] got_q[$];

  always @(negedge clk) begin
    if (rst_n && rnd_valid) valid_cnt++;
    if (rst_n && rnd_valid && rnd_ready) got_q.push_back(rnd_word);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) rnd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed(input logic b);
    raw_bit = b;
    en = 1'b1;
    repeat (SAMPLE_DIV) step();
  endtask

  task automatic feed_seq(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) feed(s[i]);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_clr();
    en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0]      samp;
    int               n;
    int               nwords;
    logic [WIDTH-1:0] word;
  } vec_t;

  vec_t vecs[6];
  bit   samp_q[$];
  logic [WIDTH-1:0] exp_q[$];

  initial begin
    int base, vbase, run, nb;
    logic [WIDTH-1:0] acc;
    bit b;

    vecs[0] = '{32'h9A59,   16, 1, 8'hB2};
    vecs[1] = '{32'h65A6,   16, 1, 8'h4D};
    vecs[2] = '{32'h87A179, 24, 1, 8'hB2};
    vecs[3] = '{32'hAAAA,   16, 1, 8'hFF};
    vecs[4] = '{32'h5555,   16, 1, 8'h00};
    vecs[5] = '{32'h33,      8, 0, 8'h00};

    // Reset held with the raw input toggling
    for (int i = 0; i < 6; i++) begin
      raw_bit = ~raw_bit;
      step();
      check("reset_outputs", {rnd_word, rnd_valid, overrun, health_fail}, 0);
    end
    rst_n = 1'b1;
    raw_bit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("idle_no_valid", rnd_valid, 1'b0);
    end

    rnd_ready = 1'b1;
    foreach (vecs[v]) begin
      base  = got_q.size();
      vbase = valid_cnt;
      feed_seq(vecs[v].samp, vecs[v].n);
      idle(3);
      check($sformatf("vec%0d_words", v), got_q.size() - base, vecs[v].nwords);
      check($sformatf("vec%0d_valid_cycles", v), valid_cnt - vbase, vecs[v].nwords);
      if (vecs[v].nwords == 1 && got_q.size() > base)
        check($sformatf("vec%0d_word", v), got_q[base], vecs[v].word);
    end

    // Overrun: second word completes while the first is still held
    rnd_ready = 1'b0;
    feed_seq(32'h9A59, 16);
    idle(2);
    check("hold_valid", rnd_valid, 1'b1);
    check("hold_word", rnd_word, 8'hB2);
    check("no_overrun_yet", overrun, 1'b0);
    feed_seq(32'h65A6, 16);
    idle(2);
    check("overrun_set", overrun, 1'b1);
    check("held_word_kept", rnd_word, 8'hB2);
    check("held_valid_kept", rnd_valid, 1'b1);
    base = got_q.size();
    rnd_ready = 1'b1;
    step();
    check("accept_valid_low", rnd_valid, 1'b0);
    check("accept_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("accepted_word", got_q[base], 8'hB2);
    pulse_clr();
    check("clr_overrun", overrun, 1'b0);

    // Health test: 32 identical ticks
    for (int i = 0; i < REP_LIMIT - 1; i++) feed(1'b1);
    raw_bit = 1'b1;
    en = 1'b1;
    repeat (SAMPLE_DIV - 1) step();
    check("hf_before_last_tick", health_fail, 1'b0);
    step();
    check("hf_after_last_tick", health_fail, 1'b1);
    idle(1);
    base = got_q.size();
    feed_seq(32'h9A59, 16);
    idle(3);
    check("hf_no_words", got_q.size() - base, 0);
    check("hf_sticky", health_fail, 1'b1);
    pulse_clr();
    check("clr_hf", health_fail, 1'b0);
    base = got_q.size();
    feed_seq(32'h9A59, 16);
    idle(3);
    check("post_clr_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("post_clr_word", got_q[base], 8'hB2);

    // Asynchronous reset with a held word and a partial word in progress
    rnd_ready = 1'b0;
    feed_seq(32'h9A59, 16);
    idle(2);
    check("pre_reset_valid", rnd_valid, 1'b1);
    feed_seq(32'h269, 10);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {rnd_word, rnd_valid, overrun, health_fail}, 0);
    en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    rnd_ready = 1'b1;
    base = got_q.size();
    feed_seq(32'h9A59, 16);
    idle(3);
    check("post_reset_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("post_reset_word", got_q[base], 8'hB2);

    // en dropped between the two samples of a pair
    base = got_q.size();
    feed(1'b1);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      raw_bit = 1'($urandom_range(0, 1));
      step();
    end
    check("gap_no_valid", rnd_valid, 1'b0);
    feed(1'b0);
    feed_seq(32'h1A59, 14);
    idle(3);
    check("gap_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("gap_word", got_q[base], 8'hB2);

    // Randomised biased stream against a pair/packing reference model
    pulse_clr();
    run = 0;
    for (int i = 0; i < 320; i++) begin
      b = ($urandom_range(0, 99) < 70);
      if (samp_q.size() > 0 && b == samp_q[samp_q.size() - 1]) run++;
      else run = 1;
      if (run > 16) begin
        b = ~b;
        run = 1;
      end
      samp_q.push_back(b);
    end
    acc = '0;
    nb = 0;
    for (int i = 0; i + 1 < samp_q.size(); i += 2) begin
      if (samp_q[i] != samp_q[i + 1]) begin
        acc = {acc[WIDTH-2:0], samp_q[i]};
        nb++;
        if (nb == WIDTH) begin
          exp_q.push_back(acc);
          nb = 0;
        end
      end
    end
    base = got_q.size();
    rand_ready = 1'b1;
    foreach (samp_q[i]) feed(samp_q[i]);
    rand_ready = 1'b0;
    rnd_ready = 1'b1;
    idle(4);
    check("rand_count", got_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i < got_q.size()) check($sformatf("rand_word%0d", i), got_q[base + i], exp_q[i]);
    check("rand_overrun", overrun, 1'b0);
    check("rand_health", health_fail, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
